// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the multi-core memory round-robin arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    localparam logic [31:0] POISON_DEFAULT = 32'hDEAD_BEEF;

    // Each core sees a private image: its index scales the region offset; the sum wraps mod 2^32.
    function automatic logic [31:0] relocate(input logic [31:0] addr,
                                             input logic [31:0] idx,
                                             input logic [31:0] region_size);
        return addr + idx * region_size;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping mod N.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          found
);

    always_comb begin : pick
        int idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        // Scan last+1 .. last+N so the previous winner has lowest priority.
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Shares one memory port among NUM_CORES PicoRV32 native interfaces, one access at a time,
// with per-core address relocation and a watchdog that poisons unanswered accesses.
//
// state | meaning
// IDLE  | waiting for any c_valid; picks next core round-robin
// ISSUE | m_valid held, waiting for m_ready or watchdog expiry
// RESP  | c_ready pulse to the granted core, then back to IDLE
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          NUM_CORES   = 3,
    parameter logic [31:0] REGION_SIZE = 32'h0001_0000,
    parameter int          TIMEOUT     = 1024,
    parameter logic [31:0] POISON      = POISON_DEFAULT,
    localparam int         IW          = $clog2(NUM_CORES),
    localparam int         WW          = $clog2(TIMEOUT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CORES-1:0]    c_valid,
    input  logic [NUM_CORES-1:0]    c_instr,
    input  logic [32*NUM_CORES-1:0] c_addr,
    input  logic [32*NUM_CORES-1:0] c_wdata,
    input  logic [4*NUM_CORES-1:0]  c_wstrb,
    output logic [NUM_CORES-1:0]    c_ready,
    output logic [31:0]             c_rdata,
    output logic                    m_valid,
    output logic                    m_instr,
    output logic [31:0]             m_addr,
    output logic [31:0]             m_wdata,
    output logic [3:0]              m_wstrb,
    output logic [IW-1:0]           m_core_id,
    input  logic                    m_ready,
    input  logic [31:0]             m_rdata,
    output logic [NUM_CORES-1:0]    err
);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_instr_q, m_instr_d;
    logic [31:0]          m_addr_q, m_addr_d;
    logic [31:0]          m_wdata_q, m_wdata_d;
    logic [3:0]           m_wstrb_q, m_wstrb_d;
    logic [NUM_CORES-1:0] c_ready_q, c_ready_d;
    logic [31:0]          c_rdata_q, c_rdata_d;
    logic [NUM_CORES-1:0] err_q, err_d;
    logic [WW-1:0]        wdog_q, wdog_d;

    logic [IW-1:0]        pick_idx;
    logic                 pick_found;
    logic [31:0]          sel_addr, sel_wdata;
    logic [3:0]           sel_wstrb;
    logic                 sel_instr;

    rr_pick #(.N(NUM_CORES), .IW(IW)) u_pick (
        .req   (c_valid),
        .last  (last_q),
        .grant (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        sel_instr = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_addr  = c_addr[32*i +: 32];
                sel_wdata = c_wdata[32*i +: 32];
                sel_wstrb = c_wstrb[4*i +: 4];
                sel_instr = c_instr[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        m_valid_d = m_valid_q;
        m_instr_d = m_instr_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        c_ready_d = c_ready_q;
        c_rdata_d = c_rdata_q;
        err_d     = err_q;
        wdog_d    = wdog_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d   = pick_idx;
                    last_d    = pick_idx;
                    m_addr_d  = relocate(sel_addr, 32'(pick_idx), REGION_SIZE);
                    m_wdata_d = sel_wdata;
                    m_wstrb_d = sel_wstrb;
                    m_instr_d = sel_instr;
                    m_valid_d = 1'b1;
                    wdog_d    = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // A response landing on the expiry cycle is real data, so it takes precedence.
                if (m_ready) begin
                    c_rdata_d = m_rdata;
                    c_ready_d = NUM_CORES'(1) << grant_q;
                    m_valid_d = 1'b0;
                    wdog_d    = '0;
                    state_d   = RESP;
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    c_rdata_d = POISON;
                    c_ready_d = NUM_CORES'(1) << grant_q;
                    err_d     = err_q | (NUM_CORES'(1) << grant_q);
                    m_valid_d = 1'b0;
                    wdog_d    = '0;
                    state_d   = RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            RESP: begin
                c_ready_d = '0;
                state_d   = IDLE;
            end
            default: begin
                c_ready_d = '0;
                m_valid_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= IW'(NUM_CORES - 1);
            grant_q   <= '0;
            m_valid_q <= 1'b0;
            m_instr_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            c_ready_q <= '0;
            c_rdata_q <= '0;
            err_q     <= '0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            m_valid_q <= m_valid_d;
            m_instr_q <= m_instr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
            c_ready_q <= c_ready_d;
            c_rdata_q <= c_rdata_d;
            err_q     <= err_d;
            wdog_q    <= wdog_d;
        end
    end

    assign c_ready   = c_ready_q;
    assign c_rdata   = c_rdata_q;
    assign m_valid   = m_valid_q;
    assign m_instr   = m_instr_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_wstrb   = m_wstrb_q;
    assign m_core_id = grant_q;
    assign err       = err_q;

endmodule
